hex_display_ctrl: RTL and testbench
===================================

Name: hex_display_ctrl

Overview:
- Control front-end for the board's switch-to-hex display datapath.
- Synchronises and settles the 10 slide switches, and debounces the active-low KEY0 push button into a binary / two's-complement mode toggle.
- Computes the 16-bit display word and hands it to the downstream hex-encoder stage over a valid/ready handshake.
- Sits between the board pins and the 7-segment encoders.

Parameters:
- DEBOUNCE_CYCLES, 500000, cycles KEY0 must be stable before a press or release is accepted (10 ms at 50 MHz).
- SETTLE_CYCLES, 500000, cycles the synchronised switch vector must be unchanged before it is accepted.
- SW_W, 10, switch vector width.
- DISP_W, 16, display word width (four hex digits).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sw  in  SW_W  raw slide switches, asynchronous.
- key0_n  in  1  raw KEY0; 0 = pressed; asynchronous.
- ledr  out  SW_W  registered copy of the accepted switch vector.
- mode  out  1  0 = binary, 1 = two's complement.
- disp_data  out  DISP_W  display word.
- disp_valid  out  1  disp_data holds an unconsumed update.
- disp_ready  in  1  downstream accepts the update.

Behaviour:
- Reset (rst sampled high at a clk edge):
  - mode=0, ledr=0, disp_data=0, disp_valid=0.
  - Synchronisers load 0 and 1 (key released).
  - Counters clear; debounce FSM goes to IDLE.
  - An internal init_pend flag is set.
- rst asserted mid-operation aborts any pending handshake: disp_valid drops at that edge.
- Synchronisers: sw and key0_n each pass through two flops before use.
- Switch settle:
  - A candidate register is compared with the synchronised sw.
  - On a difference: load the candidate and clear the counter.
  - On equality: increment, saturating at SETTLE_CYCLES-1.
  - On the cycle the counter reaches SETTLE_CYCLES-1 and the candidate differs from ledr (or init_pend=1), raise an internal update strobe.
  - Latency from a clean sw change to disp_valid high is SETTLE_CYCLES+3 clocks.
  - Glitches shorter than SETTLE_CYCLES never produce an update.
- Key debounce FSM, states IDLE / PRESS_WAIT / HELD / RELEASE_WAIT:
  - IDLE -> PRESS_WAIT when the synchronised key is 0.
  - PRESS_WAIT -> IDLE if the key returns to 1 before the counter reaches DEBOUNCE_CYCLES-1; otherwise -> HELD.
  - On the transition into HELD: mode toggles and the update strobe is raised.
  - HELD -> RELEASE_WAIT when the key is 1.
  - RELEASE_WAIT -> HELD if the key drops back to 0 before DEBOUNCE_CYCLES-1; otherwise -> IDLE.
  - Exactly one toggle occurs per accepted press; a held key never retoggles.
- Display word:
  - mode=0: disp_data = zero-extended candidate.
  - mode=1: the candidate is read as signed SW_W, negated, and sign-extended to DISP_W.
  - Examples: 0x001->0xFFFF, 0x00A->0xFFF6, 0x3FF->0x0001, 0x200->0x0200, 0x000->0x0000.
  - The word is computed from the post-toggle mode and the settled switch value.
- Update strobe:
  - On the next edge, ledr and disp_data are loaded, disp_valid is set, and init_pend is cleared.
  - A mode toggle and a switch acceptance in the same cycle produce one update with both changes applied.
- Handshake:
  - Transfer occurs at an edge where disp_valid=1 and disp_ready=1; disp_valid then clears unless a new strobe occurs in the same cycle, in which case it stays 1 with the new data.
  - While disp_valid=1 and disp_ready=0, disp_data is stable, except that a new strobe overwrites it (latest value wins; no queue).
  - disp_valid never drops without a transfer, except on rst.
- Counter widths are $clog2 of the respective parameter; both parameters must be >=2.

Decomposition:
- Package hex_disp_pkg holds:
  - the mode enum (MODE_BIN, MODE_TWOS);
  - the debounce state enum;
  - the DISP_W and SW_W constants;
  - a to_display(value, mode) function implementing the word rule.
- One sub-module, key_debouncer (synchroniser, counter and FSM), outputs a single-cycle press_pulse.
- The top level holds the settle logic, mode register and handshake.

Test Plan (DEBOUNCE_CYCLES=4, SETTLE_CYCLES=4, disp_ready=1 unless stated):
1. Release rst with sw=0x00A, key0_n=1 -> disp_valid pulses once with disp_data=0x000A, ledr=0x00A, mode=0, exactly 7 clocks after the release edge.
2. Hold key0_n=0 for 10 clocks with sw=0x00A -> mode=1 and one update 0xFFF6. A 2-clock low glitch -> no toggle. Holding the key low for 100 clocks -> still a single toggle.
3. In mode=1, step sw through 0x001, 0x3FF, 0x200 (each held 10 clocks) -> successive updates 0xFFFF, 0x0001, 0x0200. A 2-clock sw glitch -> no update.
4. disp_ready=0, then sw 0x005 followed by 0x006 -> disp_valid stays 1 and disp_data is replaced 0x0005 -> 0x0006. Raising disp_ready -> one transfer of 0x0006, then disp_valid=0.
5. sw change and accepted key press timed to land in the same cycle (sw=0x003, mode 0->1) -> a single update of 0xFFFD.
6. Assert rst for one cycle while disp_valid=1 and in HELD -> all outputs at reset values next cycle. After release with sw and key unchanged, the init update republishes the binary value; no toggle occurs until the key is released and pressed again.

Source files
------------

// File: rtl/hex_disp_pkg.sv
// Shared types, widths and the switch-to-display word rule for the hex display
// control front-end.
package hex_disp_pkg;

  localparam int SW_W   = 10;
  localparam int DISP_W = 16;

  typedef enum logic {
    MODE_BIN  = 1'b0,
    MODE_TWOS = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    DB_IDLE         = 2'd0,
    DB_PRESS_WAIT   = 2'd1,
    DB_HELD         = 2'd2,
    DB_RELEASE_WAIT = 2'd3
  } db_state_e;

  // Sign-extend before negating so that the most negative switch value (0x200)
  // maps to +512 instead of wrapping back to itself.
  function automatic logic [DISP_W-1:0] to_display(input logic [SW_W-1:0] value,
                                                   input mode_e mode);
    logic [DISP_W-1:0] ext;
    ext = {{(DISP_W-SW_W){value[SW_W-1]}}, value};
    if (mode == MODE_TWOS) begin
      to_display = ~ext + DISP_W'(1);
    end else begin
      to_display = {{(DISP_W-SW_W){1'b0}}, value};
    end
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Synchronises and debounces the active-low KEY0 button; emits one press_pulse
// per accepted press.
module key_debouncer
  import hex_disp_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key0_n,
  output logic press_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             key_meta_r;
  logic             key_sync_r;
  logic [1:0]       fill_r;
  logic             armed_r;
  logic [CNT_W-1:0] cnt_r;
  db_state_e        state_r;

  // Synchroniser, debounce counter and press/release state machine.
  // A key already held at reset must be seen released (debounced) before a press
  // is accepted; fill_r masks the synchroniser's reset values while it refills.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_meta_r  <= 1'b1;
      key_sync_r  <= 1'b1;
      fill_r      <= 2'b00;
      armed_r     <= 1'b0;
      cnt_r       <= '0;
      state_r     <= DB_IDLE;
      press_pulse <= 1'b0;
    end else begin
      key_meta_r  <= key0_n;
      key_sync_r  <= key_meta_r;
      fill_r      <= {fill_r[0], 1'b1};
      press_pulse <= 1'b0;
      case (state_r)
        DB_IDLE: begin
          if (key_sync_r) begin
            if (!armed_r && fill_r[1]) begin
              if (cnt_r == CNT_MAX) begin
                armed_r <= 1'b1;
              end else begin
                cnt_r <= cnt_r + CNT_W'(1);
              end
            end
          end else begin
            cnt_r <= '0;
            if (armed_r) begin
              state_r <= DB_PRESS_WAIT;
            end
          end
        end
        DB_PRESS_WAIT: begin
          if (key_sync_r) begin
            state_r <= DB_IDLE;
            cnt_r   <= '0;
          end else if (cnt_r == CNT_MAX) begin
            state_r     <= DB_HELD;
            cnt_r       <= '0;
            press_pulse <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        DB_HELD: begin
          cnt_r <= '0;
          if (key_sync_r) begin
            state_r <= DB_RELEASE_WAIT;
          end
        end
        DB_RELEASE_WAIT: begin
          if (!key_sync_r) begin
            state_r <= DB_HELD;
            cnt_r   <= '0;
          end else if (cnt_r == CNT_MAX) begin
            state_r <= DB_IDLE;
            cnt_r   <= '0;
            armed_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= DB_IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hex_display_ctrl.sv
// Switch settle, mode register and valid/ready publication of the 16-bit display
// word toward the 7-segment encoder stage.
module hex_display_ctrl
  import hex_disp_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SETTLE_CYCLES   = 500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SW_W-1:0]   sw,
  input  logic              key0_n,
  output logic [SW_W-1:0]   ledr,
  output logic              mode,
  output logic [DISP_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              disp_ready
);

  localparam int SET_W = $clog2(SETTLE_CYCLES);
  localparam logic [SET_W-1:0] SET_MAX = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [SET_W-1:0] SET_PRE = SET_W'(SETTLE_CYCLES - 2);

  logic [SW_W-1:0]  sw_meta_r;
  logic [SW_W-1:0]  sw_sync_r;
  logic [SW_W-1:0]  cand_r;
  logic [SET_W-1:0] settle_cnt_r;
  logic             hit_r;
  logic             init_pend_r;
  mode_e            mode_r;

  logic             press_pulse_s;
  logic             sw_upd_s;
  logic             strobe_s;
  logic [SW_W-1:0]  value_s;
  mode_e            mode_nxt_s;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debouncer (
    .clk        (clk),
    .rst        (rst),
    .key0_n     (key0_n),
    .press_pulse(press_pulse_s)
  );

  // Switch synchroniser and settle counter; hit_r pulses once when the counter
  // first reaches its saturation value.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta_r    <= '0;
      sw_sync_r    <= '0;
      cand_r       <= '0;
      settle_cnt_r <= '0;
      hit_r        <= 1'b0;
    end else begin
      sw_meta_r <= sw;
      sw_sync_r <= sw_meta_r;
      if (sw_sync_r != cand_r) begin
        cand_r       <= sw_sync_r;
        settle_cnt_r <= '0;
        hit_r        <= 1'b0;
      end else begin
        hit_r <= (settle_cnt_r == SET_PRE);
        if (settle_cnt_r != SET_MAX) begin
          settle_cnt_r <= settle_cnt_r + SET_W'(1);
        end
      end
    end
  end

  assign sw_upd_s = hit_r && ((cand_r != ledr) || init_pend_r);
  assign strobe_s = sw_upd_s || press_pulse_s;

  // Settled value and post-toggle mode feeding the next published word.
  always_comb begin
    value_s    = ledr;
    mode_nxt_s = mode_r;
    if (sw_upd_s) begin
      value_s = cand_r;
    end else begin
      value_s = ledr;
    end
    if (press_pulse_s) begin
      mode_nxt_s = (mode_r == MODE_BIN) ? MODE_TWOS : MODE_BIN;
    end else begin
      mode_nxt_s = mode_r;
    end
  end

  // Output registers and handshake: a new strobe always overwrites, a transfer
  // clears valid only when nothing new arrives in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_r      <= MODE_BIN;
      ledr        <= '0;
      disp_data   <= '0;
      disp_valid  <= 1'b0;
      init_pend_r <= 1'b1;
    end else begin
      mode_r <= mode_nxt_s;
      if (strobe_s) begin
        ledr        <= value_s;
        disp_data   <= to_display(value_s, mode_nxt_s);
        disp_valid  <= 1'b1;
        init_pend_r <= 1'b0;
      end else if (disp_ready) begin
        disp_valid <= 1'b0;
      end
    end
  end

  assign mode = mode_r;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed self-checking bench for hex_display_ctrl with short debounce/settle
// windows (4 cycles each).
module tb_hex_display_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  sw;
  logic        key0_n;
  logic [9:0]  ledr;
  logic        mode;
  logic [15:0] disp_data;
  logic        disp_valid;
  logic        disp_ready;

  int n_checks = 0;
  int n_errors = 0;
  int xfer_cnt = 0;
  logic [15:0] last_xfer = 16'h0000;
  int base;

  logic [9:0]  t3_sw  [3] = '{10'h001, 10'h3FF, 10'h200};
  logic [15:0] t3_exp [3] = '{16'hFFFF, 16'h0001, 16'h0200};

  hex_display_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .SETTLE_CYCLES  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .key0_n    (key0_n),
    .ledr      (ledr),
    .mode      (mode),
    .disp_data (disp_data),
    .disp_valid(disp_valid),
    .disp_ready(disp_ready)
  );

  always #5 clk = ~clk;

  // Transfer monitor: counts accepted words and remembers the last one.
  always @(posedge clk) begin
    if (!rst && disp_valid && disp_ready) begin
      xfer_cnt  <= xfer_cnt + 1;
      last_xfer <= disp_data;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_release();
    key0_n = 1'b0;
    tick(10);
    key0_n = 1'b1;
    tick(12);
  endtask

  initial begin
    rst = 1'b1; sw = 10'h00A; key0_n = 1'b1; disp_ready = 1'b1;
    tick(3);
    check_val("rst_mode", mode, 0);
    check_val("rst_ledr", ledr, 0);
    check_val("rst_data", disp_data, 0);
    check_val("rst_valid", disp_valid, 0);

    // 1: init update exactly 7 clocks after reset release
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      check_val("t1_valid_lat", disp_valid, (k == 7));
    end
    check_val("t1_data", disp_data, 16'h000A);
    check_val("t1_ledr", ledr, 10'h00A);
    check_val("t1_mode", mode, 0);
    tick(1);
    check_val("t1_valid_drop", disp_valid, 0);
    check_val("t1_xfers", xfer_cnt, 1);

    // 2: accepted press, glitch, long hold
    base = xfer_cnt;
    key0_n = 1'b0;
    tick(10);
    check_val("t2_mode", mode, 1);
    check_val("t2_data", disp_data, 16'hFFF6);
    key0_n = 1'b1;
    tick(12);
    check_val("t2_xfers", xfer_cnt, base + 1);
    check_val("t2_last", last_xfer, 16'hFFF6);

    base = xfer_cnt;
    key0_n = 1'b0;
    tick(2);
    key0_n = 1'b1;
    tick(12);
    check_val("t2_glitch_mode", mode, 1);
    check_val("t2_glitch_xfers", xfer_cnt, base);

    base = xfer_cnt;
    key0_n = 1'b0;
    tick(100);
    check_val("t2_hold_mode", mode, 0);
    check_val("t2_hold_xfers", xfer_cnt, base + 1);
    check_val("t2_hold_last", last_xfer, 16'h000A);
    key0_n = 1'b1;
    tick(12);
    press_release();
    check_val("t2_back_twos", mode, 1);

    // 3: two's-complement words, then a short switch glitch
    for (int i = 0; i < 3; i++) begin
      base = xfer_cnt;
      sw = t3_sw[i];
      tick(10);
      check_val("t3_xfers", xfer_cnt, base + 1);
      check_val("t3_last", last_xfer, t3_exp[i]);
      check_val("t3_ledr", ledr, t3_sw[i]);
    end
    base = xfer_cnt;
    sw = 10'h0F0;
    tick(2);
    sw = 10'h200;
    tick(12);
    check_val("t3_glitch_xfers", xfer_cnt, base);
    check_val("t3_glitch_ledr", ledr, 10'h200);

    // 4: backpressure, latest value wins
    press_release();
    check_val("t4_mode_bin", mode, 0);
    check_val("t4_last", last_xfer, 16'h0200);
    disp_ready = 1'b0;
    base = xfer_cnt;
    sw = 10'h005;
    tick(10);
    check_val("t4_valid_a", disp_valid, 1);
    check_val("t4_data_a", disp_data, 16'h0005);
    sw = 10'h006;
    tick(10);
    check_val("t4_valid_b", disp_valid, 1);
    check_val("t4_data_b", disp_data, 16'h0006);
    check_val("t4_no_xfer", xfer_cnt, base);
    disp_ready = 1'b1;
    tick(1);
    check_val("t4_valid_drop", disp_valid, 0);
    check_val("t4_xfers", xfer_cnt, base + 1);
    check_val("t4_last_b", last_xfer, 16'h0006);

    // 5: key toggle and switch acceptance land on the same edge
    base = xfer_cnt;
    key0_n = 1'b0;
    tick(1);
    sw = 10'h003;
    tick(20);
    check_val("t5_xfers", xfer_cnt, base + 1);
    check_val("t5_last", last_xfer, 16'hFFFD);
    check_val("t5_ledr", ledr, 10'h003);
    check_val("t5_mode", mode, 1);

    // 6: reset while valid and key held
    disp_ready = 1'b0;
    sw = 10'h007;
    tick(10);
    check_val("t6_pre_valid", disp_valid, 1);
    check_val("t6_pre_data", disp_data, 16'hFFF9);
    rst = 1'b1;
    tick(1);
    check_val("t6_rst_mode", mode, 0);
    check_val("t6_rst_ledr", ledr, 0);
    check_val("t6_rst_data", disp_data, 0);
    check_val("t6_rst_valid", disp_valid, 0);
    rst = 1'b0;
    disp_ready = 1'b1;
    base = xfer_cnt;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      check_val("t6_valid_lat", disp_valid, (k == 7));
    end
    check_val("t6_init_data", disp_data, 16'h0007);
    tick(30);
    check_val("t6_held_mode", mode, 0);
    check_val("t6_held_xfers", xfer_cnt, base + 1);
    key0_n = 1'b1;
    tick(12);
    press_release();
    check_val("t6_repress_mode", mode, 1);
    check_val("t6_repress_last", last_xfer, 16'hFFF9);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
